// File: rtl/jtcps1_obj_pkg.sv
// Shared constants and FSM encoding for the CPS1 object line-buffer scheduler.
package jtcps1_obj_pkg;
  localparam int OBJ_AW = 9;
  localparam int OBJ_PW = 9;
  localparam logic [OBJ_PW-1:0] OBJ_BLANK = 9'h1FF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    PEND  = 2'd3
  } sched_state_t;
endpackage

// File: rtl/jtcps1_obj_line_sched_if.sv
// Scheduler <-> object draw engine handshake and line-buffer write bus.
interface jtcps1_obj_line_sched_if
  import jtcps1_obj_pkg::*;
#(
  parameter int AW = OBJ_AW
);
  logic              draw_start;
  logic [8:0]        draw_line;
  logic              draw_done;
  logic [AW-1:0]     dr_addr;
  logic [OBJ_PW-1:0] dr_data;
  logic              dr_wr;

  modport master (
    output draw_start, draw_line,
    input  draw_done, dr_addr, dr_data, dr_wr
  );

  modport slave (
    input  draw_start, draw_line,
    output draw_done, dr_addr, dr_data, dr_wr
  );
endinterface

// File: rtl/jtcps1_obj_lbport.sv
// One line-buffer RAM port: draw-write pass-through, front-side read, or erase.
module jtcps1_obj_lbport
  import jtcps1_obj_pkg::*;
#(
  parameter int                AW    = OBJ_AW,
  parameter logic [OBJ_PW-1:0] BLANK = OBJ_BLANK
) (
  input  logic              front,
  input  logic              erase,
  input  logic [AW-1:0]     hdump,
  input  logic [AW-1:0]     erase_addr,
  input  logic [AW-1:0]     dr_addr,
  input  logic [OBJ_PW-1:0] dr_data,
  input  logic              dr_we,
  output logic [AW-1:0]     addr,
  output logic [OBJ_PW-1:0] data,
  output logic              we
);
  // Erase wins over role so a buffer swap between read and erase still clears it.
  always_comb begin
    addr = dr_addr;
    data = dr_data;
    we   = dr_we;
    if (erase) begin
      addr = erase_addr;
      data = BLANK;
      we   = 1'b1;
    end else if (front) begin
      addr = hdump;
      data = BLANK;
      we   = 1'b0;
    end
  end
endmodule

// File: rtl/jtcps1_obj_line_sched.sv
// Ping-pong object line buffers: launches one draw per line, routes draw writes
// to the back buffer, streams the front buffer to the mixer with erase-after-read.
module jtcps1_obj_line_sched
  import jtcps1_obj_pkg::*;
#(
  parameter logic [OBJ_PW-1:0] BLANK = OBJ_BLANK,
  parameter int                AW    = OBJ_AW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pxl_cen,
  input  logic                    line_start,
  input  logic [8:0]              vrender,
  input  logic                    obj_en,
  jtcps1_obj_line_sched_if.master draw,
  input  logic [AW-1:0]           hdump,
  output logic [OBJ_PW-1:0]       pxl,
  output logic [AW-1:0]           lb0_addr,
  output logic [AW-1:0]           lb1_addr,
  output logic [OBJ_PW-1:0]       lb0_data,
  output logic [OBJ_PW-1:0]       lb1_data,
  output logic                    lb0_we,
  output logic                    lb1_we,
  input  logic [OBJ_PW-1:0]       lb0_q,
  input  logic [OBJ_PW-1:0]       lb1_q,
  output logic                    overrun
);
  sched_state_t state, nxt;
  logic          wsel, toggle, ovr;
  logic [8:0]    line_q;
  logic          rd_ph, rd_sel;
  logic [AW-1:0] rd_addr;
  logic          dr_we;

  logic [1:0]             front, erase;
  logic [1:0][AW-1:0]     lb_addr;
  logic [1:0][OBJ_PW-1:0] lb_data;
  logic [1:0]             lb_we;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= nxt;

  // Simultaneous done+line_start retires the old line first, then takes the new one.
  always_comb begin
    nxt    = state;
    toggle = 1'b0;
    ovr    = 1'b0;
    case (state)
      IDLE:
        if (line_start) begin
          toggle = 1'b1;
          nxt    = obj_en ? START : IDLE;
        end
      START:
        if (line_start) begin
          toggle = 1'b1;
          ovr    = 1'b1;
          nxt    = PEND;
        end else begin
          nxt = BUSY;
        end
      BUSY:
        if (draw.draw_done) begin
          toggle = line_start;
          nxt    = (line_start && obj_en) ? START : IDLE;
        end else if (line_start) begin
          toggle = 1'b1;
          ovr    = 1'b1;
          nxt    = PEND;
        end
      PEND: begin
        toggle = line_start;
        ovr    = line_start && !draw.draw_done;
        if (draw.draw_done) nxt = obj_en ? START : IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wsel    <= 1'b0;
      line_q  <= '0;
      overrun <= 1'b0;
      rd_ph   <= 1'b0;
      rd_sel  <= 1'b0;
      rd_addr <= '0;
      pxl     <= BLANK;
    end else begin
      overrun <= ovr;
      if (toggle) begin
        wsel   <= ~wsel;
        line_q <= vrender;
      end
      rd_ph <= pxl_cen;
      if (pxl_cen) begin
        rd_addr <= hdump;
        rd_sel  <= ~wsel;
      end
      if (rd_ph) pxl <= rd_sel ? lb1_q : lb0_q;
    end

  assign draw.draw_start = (state == START);
  assign draw.draw_line  = line_q;

  // A stale draw still running in PEND must not touch the new back buffer.
  assign dr_we = draw.dr_wr && (state != PEND);
  assign front = {~wsel, wsel};
  assign erase = {rd_ph & rd_sel, rd_ph & ~rd_sel};

  for (genvar i = 0; i < 2; i++) begin : g_lb
    jtcps1_obj_lbport #(.AW(AW), .BLANK(BLANK)) u_port (
      .front      (front[i]),
      .erase      (erase[i]),
      .hdump      (hdump),
      .erase_addr (rd_addr),
      .dr_addr    (draw.dr_addr),
      .dr_data    (draw.dr_data),
      .dr_we      (dr_we),
      .addr       (lb_addr[i]),
      .data       (lb_data[i]),
      .we         (lb_we[i])
    );
  end

  assign lb0_addr = lb_addr[0];
  assign lb1_addr = lb_addr[1];
  assign lb0_data = lb_data[0];
  assign lb1_data = lb_data[1];
  assign lb0_we   = lb_we[0];
  assign lb1_we   = lb_we[1];
endmodule

// File: tb/tb_jtcps1_obj_line_sched.sv
// Randomized bench for the object line scheduler against a per-line buffer model.
module tb_jtcps1_obj_line_sched;
  localparam logic [8:0] BLANK = 9'h1FF;

  logic       clk = 1'b0;
  logic       rst;
  logic       pxl_cen, line_start, obj_en;
  logic [8:0] vrender, hdump, pxl;
  logic [8:0] lb0_addr, lb1_addr, lb0_data, lb1_data, lb0_q, lb1_q;
  logic       lb0_we, lb1_we, overrun;

  jtcps1_obj_line_sched_if #(.AW(9)) dif ();

  jtcps1_obj_line_sched dut (
    .clk(clk), .rst(rst), .pxl_cen(pxl_cen), .line_start(line_start),
    .vrender(vrender), .obj_en(obj_en), .draw(dif.master), .hdump(hdump),
    .pxl(pxl), .lb0_addr(lb0_addr), .lb1_addr(lb1_addr),
    .lb0_data(lb0_data), .lb1_data(lb1_data), .lb0_we(lb0_we), .lb1_we(lb1_we),
    .lb0_q(lb0_q), .lb1_q(lb1_q), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Line RAMs: synchronous read, cleared while reset is held.
  logic [8:0] mem [2][512];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) begin
        mem[0][i] <= BLANK;
        mem[1][i] <= BLANK;
      end
    end else begin
      if (lb0_we) mem[0][lb0_addr] <= lb0_data;
      if (lb1_we) mem[1][lb1_addr] <= lb1_data;
    end
    lb0_q <= mem[0][lb0_addr];
    lb1_q <= mem[1][lb1_addr];
  end

  int ovr_seen = 0, st_seen = 0;
  always @(negedge clk) begin
    if (overrun)        ovr_seen <= ovr_seen + 1;
    if (dif.draw_start) st_seen  <= st_seen + 1;
  end

  // Model: expected content of each buffer and which one is currently back.
  logic [8:0] ref_mem [2][512];
  bit         ref_wsel;
  int         exp_ovr = 0;
  int         n_chk = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic new_line(input logic [8:0] v, input logic en);
    line_start = 1'b1; vrender = v; obj_en = en;
    tick();
    line_start = 1'b0;
    ref_wsel = ~ref_wsel;
  endtask

  task automatic wr_px(input logic [8:0] a, input logic [8:0] d, input bit land);
    dif.dr_addr = a; dif.dr_data = d; dif.dr_wr = 1'b1;
    #1;
    if (land) begin
      chk("back_we", {lb1_we, lb0_we}, ref_wsel ? 2'b10 : 2'b01);
      ref_mem[ref_wsel][a] = d;
    end else begin
      chk("pend_we", {lb1_we, lb0_we}, 2'b00);
    end
    tick();
    dif.dr_wr = 1'b0;
  endtask

  task automatic rand_writes(input int n, input bit land);
    for (int i = 0; i < n; i++) wr_px(9'($urandom_range(0, 447)), 9'($urandom_range(0, 511)), land);
  endtask

  task automatic done_pulse();
    dif.draw_done = 1'b1;
    tick();
    dif.draw_done = 1'b0;
  endtask

  // Launch a drawn line and check the start pulse timing.
  task automatic drawn_line(input logic [8:0] v);
    new_line(v, 1'b1);
    chk("start_hi", dif.draw_start, 1'b1);
    chk("draw_line", dif.draw_line, v);
    tick();
    chk("start_lo", dif.draw_start, 1'b0);
  endtask

  task automatic sweep();
    bit fb;
    logic [8:0] e;
    fb = ~ref_wsel;
    for (int h = 0; h < 448; h++) begin
      hdump = 9'(h); pxl_cen = 1'b1;
      tick();
      pxl_cen = 1'b0;
      tick();
      e = ref_mem[fb][h];
      ref_mem[fb][h] = BLANK;
      chk($sformatf("pxl[%0d]", h), pxl, e);
    end
    chk("erased", mem[fb][$urandom_range(0, 447)], BLANK);
  endtask

  initial begin
    bit fb;
    rst = 1'b1; pxl_cen = 0; line_start = 0; obj_en = 0; vrender = 0; hdump = 0;
    dif.draw_done = 0; dif.dr_addr = 0; dif.dr_data = 0; dif.dr_wr = 0;
    ref_wsel = 0;
    for (int i = 0; i < 512; i++) begin ref_mem[0][i] = BLANK; ref_mem[1][i] = BLANK; end
    repeat (3) tick();
    chk("rst_start", dif.draw_start, 1'b0);
    chk("rst_line", dif.draw_line, 9'd0);
    chk("rst_pxl", pxl, BLANK);
    chk("rst_ovr", overrun, 1'b0);
    chk("rst_we", {lb1_we, lb0_we}, 2'b00);
    chk("rst_addr", {lb1_addr, lb0_addr}, 18'd0);
    rst = 1'b0;
    tick();

    sweep();
    chk("ovr_none", ovr_seen, 0);

    // Basic draw, readout with erase, and a blank second pass.
    drawn_line(9'd40);
    wr_px(9'd100, 9'h0A5, 1);
    for (int i = 0; i < 6; i++) begin
      logic [8:0] a;
      a = 9'($urandom_range(0, 447));
      if (a == 9'd100) a = 9'd101;
      wr_px(a, 9'($urandom_range(0, 511)), 1);
    end
    chk("landed", mem[ref_wsel][100], 9'h0A5);
    done_pulse();
    new_line(9'd41, 1'b0);
    fb = ~ref_wsel;
    sweep();
    chk("erase100", mem[fb][100], BLANK);
    new_line(9'd42, 1'b0);
    sweep();
    new_line(9'd43, 1'b0);
    sweep();

    // Overrun: line_start while busy, stale writes gated, restart on done.
    drawn_line(9'd50);
    rand_writes(4, 1);
    new_line(9'd60, 1'b1); exp_ovr++;
    rand_writes(3, 0);
    chk("ovr_one", ovr_seen, exp_ovr);
    new_line(9'd61, 1'b1); exp_ovr++;
    rand_writes(2, 0);
    chk("ovr_two", ovr_seen, exp_ovr);
    done_pulse();
    chk("restart", dif.draw_start, 1'b1);
    chk("restart_line", dif.draw_line, 9'd61);
    tick();
    rand_writes(5, 1);
    done_pulse();
    new_line(9'd62, 1'b0);
    sweep();

    // draw_done and line_start together: no overrun, single toggle.
    drawn_line(9'd70);
    rand_writes(3, 1);
    line_start = 1'b1; vrender = 9'd71; obj_en = 1'b1; dif.draw_done = 1'b1;
    tick();
    line_start = 1'b0; dif.draw_done = 1'b0;
    ref_wsel = ~ref_wsel;
    chk("sim_start", dif.draw_start, 1'b1);
    chk("sim_line", dif.draw_line, 9'd71);
    tick();
    chk("sim_ovr", ovr_seen, exp_ovr);
    rand_writes(3, 1);
    done_pulse();
    new_line(9'd72, 1'b0);
    sweep();

    // Layer disabled: no draw, following line blank.
    begin
      int st0;
      st0 = st_seen;
      new_line(9'd80, 1'b0);
      repeat (4) tick();
      chk("dis_nostart", st_seen, st0);
      chk("dis_line", dif.draw_line, 9'd80);
    end
    new_line(9'd81, 1'b0);
    sweep();

    // Buffer swap between the read and erase cycles.
    drawn_line(9'd90);
    wr_px(9'd200, 9'h1C3, 1);
    done_pulse();
    new_line(9'd91, 1'b0);
    fb = ~ref_wsel;
    hdump = 9'd200; pxl_cen = 1'b1;
    tick();
    pxl_cen = 1'b0;
    line_start = 1'b1; vrender = 9'd92; obj_en = 1'b0;
    tick();
    line_start = 1'b0;
    chk("swap_pxl", pxl, 9'h1C3);
    ref_mem[fb][200] = BLANK;
    ref_wsel = ~ref_wsel;
    tick();
    chk("swap_erase", mem[fb][200], BLANK);

    for (int r = 0; r < 3; r++) begin
      drawn_line(9'($urandom_range(0, 261)));
      rand_writes(int'($urandom_range(4, 12)), 1);
      done_pulse();
      new_line(9'($urandom_range(0, 261)), 1'($urandom_range(0, 1)));
      if (dif.draw_start) begin
        tick();
        done_pulse();
      end
      sweep();
    end
    chk("ovr_final", ovr_seen, exp_ovr);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/jtcps1_obj_line_sched.md
Name: jtcps1_obj_line_sched

Overview:
- Scheduler for the CPS1 object scanline pipeline: owns two line buffers (ping-pong), triggers the object draw engine once per line, routes its buffer writes to the back buffer, and streams the front buffer to the mixer with erase-after-read.
- Sits between the video timing generator, jtcps1_obj_draw, and two 512x9 synchronous-read line RAMs.

Parameters:
- BLANK, 9'h1FF, transparent pixel value written on erase and returned after reset.
- AW, 9, line buffer address width.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: asynchronous, active-high
- pxl_cen  in  1  pixel clock enable; guaranteed at most one pulse every 2 clk
- line_start  in  1  single-cycle pulse at start of HBlank
- vrender  in  9  next line to render, sampled at line_start
- obj_en  in  1  object layer enable
- draw_start  out  1  single-cycle start pulse to draw engine
- draw_line  out  9  line being drawn, latched at issue
- draw_done  in  1  draw engine finished (pulse)
- dr_addr  in  AW  draw engine buffer address
- dr_data  in  9  draw engine pixel {pal,colour}
- dr_wr  in  1  draw engine write strobe
- hdump  in  AW  current output column
- pxl  out  9  object pixel to mixer
- lb0_addr/lb1_addr  out  AW  RAM addresses
- lb0_data/lb1_data  out  9  RAM write data
- lb0_we/lb1_we  out  1  RAM write enables
- lb0_q/lb1_q  in  9  RAM read data (1-cycle latency)
- overrun  out  1  single-cycle pulse: line_start while draw busy

Behaviour:
- Reset: wsel=0, state IDLE, draw_start=0, draw_line=0, pxl=BLANK, overrun=0, all we=0, addresses 0. Reset mid-draw abandons the line; draw engine is reset from the same rst.
- wsel selects back buffer (draw side); front buffer = ~wsel.
- FSM states IDLE, START, BUSY, PEND:
  - IDLE: on line_start -> toggle wsel, latch draw_line<=vrender; if obj_en go START, else stay IDLE (back buffer left erased, so the line is blank).
  - START: draw_start=1 for exactly this cycle -> BUSY.
  - BUSY: on draw_done -> IDLE. On line_start (not simultaneous with draw_done) -> toggle wsel, latch vrender, overrun pulse, -> PEND.
  - PEND: dr_wr gated off (stale line must not corrupt the new back buffer); on draw_done -> START if obj_en else IDLE. Another line_start in PEND: toggle wsel, relatch, overrun again, stay PEND.
  - draw_done and line_start in the same cycle in BUSY: treat as done first, then the IDLE line_start path (no overrun).
- Back buffer port: addr=dr_addr, data=dr_data, we=dr_wr && state!=PEND, combinational pass-through.
- Front buffer port, 2-cycle read/erase sequence:
  - Cycle k (pxl_cen=1): addr=hdump, we=0; latch hdump internally.
  - Cycle k+1: pxl<=q of front buffer; we=1, data=BLANK, addr=latched hdump.
- pxl holds between pxl_cen pulses.
- A wsel toggle between k and k+1 still completes the erase on the buffer selected at k.
- Address arithmetic is AW bits wide, wraps naturally. No range check; the draw engine limits x.

Decomposition:
- Shared package jtcps1_obj_pkg: BLANK constant, FSM state encoding, line buffer width constants (reuse AW=9, pixel width 9).
- One natural sub-module: jtcps1_obj_lbport (per-buffer mux between draw-write and read/erase roles given a role bit), instantiated twice.

Test Plan:
- Reset then pxl_cen sweep hdump 0..447 with no draw -> pxl==9'h1FF every column, overrun never pulses.
- line_start with vrender=9'd40, obj_en=1 -> draw_start pulses one cycle later for one cycle, draw_line=40; dr_wr addr 100 data 9'h0A5 lands in lb(wsel). After the next line_start, readout at hdump=100 gives pxl=9'h0A5 and that RAM location then holds 9'h1FF.
- Readout of the same buffer on a second pass (two line_starts later, no new writes at 100) -> pxl at hdump=100 is 9'h1FF.
- line_start while BUSY -> overrun pulses once; dr_wr in PEND produces no lbX_we on the back buffer. draw_done then gives draw_start on the next cycle with draw_line = newest vrender.
- line_start and draw_done in the same BUSY cycle -> no overrun, wsel toggles once, draw_start issued.
- obj_en=0 at line_start -> no draw_start, wsel toggles, following line reads all 9'h1FF.
